// File: rtl/mem_arb_pkg.sv
// Shared types and port indices for the two-port data-memory arbiter.
package mem_arb_pkg;
   typedef enum logic {IDLE, RESP} arb_state_t;
   localparam int PORT_LSU = 0;
   localparam int PORT_IF  = 1;
endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-way round-robin picker: on contention the port that
// did not win last time is chosen.
module rr_arbiter2 (
   input  logic [1:0] i_req,
   input  logic       i_last_gnt,
   output logic [1:0] o_gnt,
   output logic       o_idx
);
   always_comb begin
      o_gnt = 2'b00;
      o_idx = 1'b0;
      case (i_req)
         2'b01: begin o_gnt = 2'b01; o_idx = 1'b0; end
         2'b10: begin o_gnt = 2'b10; o_idx = 1'b1; end
         2'b11: begin
            if (i_last_gnt) begin o_gnt = 2'b01; o_idx = 1'b0; end
            else            begin o_gnt = 2'b10; o_idx = 1'b1; end
         end
         default: ;
      endcase
   end
endmodule

// File: rtl/mem_arbiter.sv
// Shares the single-port data memory between LSU (port 0) and fetch (port 1),
// sequencing the one-cycle read latency and steering rdata to the owner.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int addr_width = 10,
   parameter int data_width = 32
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [1:0]                          req,
   input  logic [1:0]                          wr_en,
   input  logic [1:0][addr_width-1:0]          addr,
   input  logic [1:0][data_width-1:0]          wdata,
   output logic [1:0]                          gnt,
   output logic [1:0]                          rvalid,
   output logic [data_width-1:0]               rdata,
   output logic                                mem_wr_en,
   output logic                                mem_rd_en,
   output logic [addr_width-1:0]               mem_addr,
   output logic [data_width-1:0]               mem_wdata,
   input  logic [data_width-1:0]               mem_rdata
);
   arb_state_t r_state;
   logic       r_owner;
   logic       r_last_gnt;

   logic [1:0] w_win_gnt;
   logic       w_win_idx;
   logic       w_grant;
   logic       w_win_wr;

   rr_arbiter2 u_rr (
      .i_req      (req),
      .i_last_gnt (r_last_gnt),
      .o_gnt      (w_win_gnt),
      .o_idx      (w_win_idx)
   );

   // Reset masks the grant combinationally so nothing reaches memory while rst is high.
   assign w_grant  = (r_state == IDLE) && !rst && (req != 2'b00);
   // Fetch never writes; its wr_en bit is ignored.
   assign w_win_wr = (w_win_idx == 1'(PORT_LSU)) && wr_en[PORT_LSU];

   assign gnt       = w_grant ? w_win_gnt : 2'b00;
   assign mem_wr_en = w_grant && w_win_wr;
   assign mem_rd_en = w_grant && !w_win_wr;
   assign mem_addr  = w_grant ? addr[w_win_idx]  : '0;
   assign mem_wdata = w_grant ? wdata[w_win_idx] : '0;

   assign rvalid = (r_state == RESP) ? (r_owner ? 2'b10 : 2'b01) : 2'b00;
   assign rdata  = (rvalid != 2'b00) ? mem_rdata : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_owner    <= 1'b0;
         r_last_gnt <= 1'b1;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_grant) begin
                  r_last_gnt <= w_win_idx;
                  if (!w_win_wr) begin
                     r_owner <= w_win_idx;
                     r_state <= RESP;
                  end
               end
            end
            RESP:    r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural one-cycle-latency memory.
module tb_mem_arbiter;
   localparam int AW = 10;
   localparam int DW = 32;

   logic                   clk = 1'b0;
   logic                   rst;
   logic [1:0]             req;
   logic [1:0]             wr_en;
   logic [1:0][AW-1:0]     addr;
   logic [1:0][DW-1:0]     wdata;
   logic [1:0]             gnt;
   logic [1:0]             rvalid;
   logic [DW-1:0]          rdata;
   logic                   mem_wr_en;
   logic                   mem_rd_en;
   logic [AW-1:0]          mem_addr;
   logic [DW-1:0]          mem_wdata;
   logic [DW-1:0]          mem_rdata;

   logic [DW-1:0]          mem [0:(1<<AW)-1];
   logic                   mem_init;

   int checks = 0;
   int errors = 0;

   mem_arbiter #(.addr_width(AW), .data_width(DW)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .wr_en     (wr_en),
      .addr      (addr),
      .wdata     (wdata),
      .gnt       (gnt),
      .rvalid    (rvalid),
      .rdata     (rdata),
      .mem_wr_en (mem_wr_en),
      .mem_rd_en (mem_rd_en),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   always #5 clk = ~clk;

   // Memory preloaded with A000_0000 | address.
   always @(posedge clk) begin
      if (mem_init) begin
         for (int k = 0; k < (1<<AW); k++) mem[k] <= 32'hA000_0000 | k;
         mem_rdata <= '0;
      end else begin
         if (mem_wr_en) mem[mem_addr] <= mem_wdata;
         if (mem_rd_en) mem_rdata <= mem[mem_addr];
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      req = 2'b00; wr_en = 2'b00;
      addr = '0; wdata = '0;
   endtask

   logic [1:0] exp_gnt [0:7];
   logic [1:0] exp_rv  [0:7];
   logic [DW-1:0] exp_rd [0:7];

   initial begin
      exp_gnt = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
      exp_rv  = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
      exp_rd  = '{32'h0, 32'hDEAD_BEEF, 32'h0, 32'hA000_0020,
                  32'h0, 32'hDEAD_BEEF, 32'h0, 32'hA000_0020};

      idle_in();
      rst = 1'b1; mem_init = 1'b1;
      cyc();
      mem_init = 1'b0;
      req = 2'b11;
      #1;
      chk("rst_gnt",    gnt, 2'b00);
      chk("rst_rvalid", rvalid, 2'b00);
      chk("rst_wr_en",  mem_wr_en, 1'b0);
      chk("rst_rd_en",  mem_rd_en, 1'b0);
      chk("rst_addr",   mem_addr, '0);
      cyc();
      rst = 1'b0; idle_in();

      // LSU write
      req = 2'b01; wr_en = 2'b01; addr[0] = 10'h010; wdata[0] = 32'hDEAD_BEEF;
      #1;
      chk("wr_gnt",   gnt, 2'b01);
      chk("wr_wr_en", mem_wr_en, 1'b1);
      chk("wr_rd_en", mem_rd_en, 1'b0);
      chk("wr_addr",  mem_addr, 10'h010);
      chk("wr_wdata", mem_wdata, 32'hDEAD_BEEF);
      cyc();
      idle_in();
      #1;
      chk("wr_mem",    mem[10'h010], 32'hDEAD_BEEF);
      chk("idle_gnt",  gnt, 2'b00);
      chk("idle_wd",   mem_wdata, '0);

      // IF read
      req = 2'b10; addr[1] = 10'h010;
      #1;
      chk("rd_gnt",   gnt, 2'b10);
      chk("rd_rd_en", mem_rd_en, 1'b1);
      chk("rd_addr",  mem_addr, 10'h010);
      cyc();
      idle_in();
      #1;
      chk("rd_gnt1",   gnt, 2'b00);
      chk("rd_rvalid", rvalid, 2'b10);
      chk("rd_rdata",  rdata, 32'hDEAD_BEEF);
      chk("rd_rd_en1", mem_rd_en, 1'b0);
      cyc();
      chk("rd_rv2",    rvalid, 2'b00);
      chk("rd_rdata2", rdata, '0);

      // Contention from reset: both ports read continuously
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      req = 2'b11; wr_en = 2'b00; addr[0] = 10'h010; addr[1] = 10'h020;
      for (int c = 0; c < 8; c++) begin
         #1;
         chk($sformatf("cont_gnt%0d", c), gnt, exp_gnt[c]);
         chk($sformatf("cont_rv%0d", c),  rvalid, exp_rv[c]);
         chk($sformatf("cont_rd%0d", c),  rdata, exp_rd[c]);
         cyc();
      end
      idle_in();

      // Write/read mix: LSU write 3ff while IF reads 020
      req = 2'b11; wr_en = 2'b01;
      addr[0] = 10'h3ff; wdata[0] = 32'h1; addr[1] = 10'h020;
      #1;
      chk("mix_gnt0",  gnt, 2'b01);
      chk("mix_wr0",   mem_wr_en, 1'b1);
      chk("mix_addr0", mem_addr, 10'h3ff);
      cyc();
      req = 2'b10; wr_en = 2'b00;
      #1;
      chk("mix_gnt1",  gnt, 2'b10);
      chk("mix_rd1",   mem_rd_en, 1'b1);
      chk("mix_addr1", mem_addr, 10'h020);
      chk("mix_mem",   mem[10'h3ff], 32'h1);
      cyc();
      idle_in();
      #1;
      chk("mix_rv2",   rvalid, 2'b10);
      chk("mix_rd2",   rdata, 32'hA000_0020);
      cyc();

      // Reset during RESP drops the response; LSU wins afterwards
      req = 2'b10; addr[1] = 10'h020;
      #1;
      chk("rmr_gnt", gnt, 2'b10);
      cyc();
      rst = 1'b1; req = 2'b11; addr[0] = 10'h010;
      #1;
      chk("rmr_gnt_rst", gnt, 2'b00);
      chk("rmr_rd_rst",  mem_rd_en, 1'b0);
      cyc();
      rst = 1'b0;
      #1;
      chk("rmr_rv",   rvalid, 2'b00);
      chk("rmr_gnt2", gnt, 2'b01);
      cyc();
      idle_in();
      #1;
      chk("rmr_rv2",  rvalid, 2'b01);
      chk("rmr_rd2",  rdata, 32'hDEAD_BEEF);
      cyc();

      // IF write attempt is performed as a read
      req = 2'b10; wr_en = 2'b10; addr[1] = 10'h020; wdata[1] = 32'hFFFF_FFFF;
      #1;
      chk("ifw_gnt",   gnt, 2'b10);
      chk("ifw_wr_en", mem_wr_en, 1'b0);
      chk("ifw_rd_en", mem_rd_en, 1'b1);
      cyc();
      idle_in();
      #1;
      chk("ifw_rv",    rvalid, 2'b10);
      chk("ifw_rd",    rdata, 32'hA000_0020);
      chk("ifw_mem",   mem[10'h020], 32'hA000_0020);
      cyc();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
